microcode_sequencer: RTL and testbench

//  Consumes the s_addr/e_addr/ena programming of the AHB micro-code controller and replays micro-code.

---
 rtl/microcode_sequencer.sv | 143 ++++++++++++++
 tb/tb_microcode_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/microcode_sequencer.sv
// microcode_sequencer: replays a range of a synchronous micro-code ROM.
// After a rising edge of ena it walks the ROM from s_addr to e_addr inclusive,
// wrapping modulo 2^AW. Each byte goes to the execution unit over a
// valid/ready handshake. The last accepted byte is kept on indata so the
// controller can read it back.
module microcode_sequencer #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic [AW-1:0] s_addr,
  input  logic [AW-1:0] e_addr,
  input  logic          ena,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_rdata,
  output logic [DW-1:0] uop_data,
  output logic          uop_valid,
  input  logic          uop_ready,
  output logic [DW-1:0] indata,
  output logic          busy,
  output logic          done
);

  // FWAIT covers the one-cycle read latency of the synchronous ROM.
  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_FWAIT,
    S_OUT,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] end_q, end_d;
  logic          ena_q;
  logic [DW-1:0] uop_data_q, uop_data_d;
  logic          uop_valid_q, uop_valid_d;
  logic [DW-1:0] indata_q, indata_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic start;
  logic handshake;

  // A run starts only on a rising edge of ena, so holding ena high never re-runs the range.
  assign start     = ena & ~ena_q;
  assign handshake = uop_valid_q & uop_ready;

  // Next-state and next-output logic for the sequencer FSM.
  always_comb begin
    // NOTE: every variable gets a default first, so no path through the case leaves it unassigned and infers a latch.
    state_d    = state_q;
    pc_d       = pc_q;
    end_d      = end_q;
    uop_data_d = uop_data_q;
    indata_d   = indata_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          // The range is captured here; later s_addr/e_addr changes do not affect the run.
          pc_d    = s_addr;
          end_d   = e_addr;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        state_d = ena ? S_FWAIT : S_IDLE;
      end
      S_FWAIT: begin
        if (!ena) begin
          state_d = S_IDLE;
        end else begin
          uop_data_d = rom_rdata;
          state_d    = S_OUT;
        end
      end
      S_OUT: begin
        if (handshake) begin
          // An accepted uop always updates indata, even when ena drops in the same cycle.
          indata_d = uop_data_q;
          if (!ena) begin
            state_d = S_IDLE;
          end else if (pc_q == end_q) begin
            state_d = S_DONE;
          end else begin
            pc_d    = pc_q + 1'b1;
            state_d = S_FETCH;
          end
        end else if (!ena) begin
          // Abort: valid drops without a handshake.
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        if (!ena) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Status outputs are registered, so they are decoded from the next state.
    uop_valid_d = (state_d == S_OUT);
    busy_d      = (state_d == S_FETCH) || (state_d == S_FWAIT) || (state_d == S_OUT);
    done_d      = (state_d == S_DONE);
  end

  // State, pc and output registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    // NOTE: async active-low reset clears every flop; non-blocking assignments keep all of them updating on the same edge.
    if (!HRESETn) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      end_q       <= '0;
      ena_q       <= 1'b0;
      uop_data_q  <= '0;
      uop_valid_q <= 1'b0;
      indata_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      end_q       <= end_d;
      ena_q       <= ena;
      uop_data_q  <= uop_data_d;
      uop_valid_q <= uop_valid_d;
      indata_q    <= indata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // The ROM address always follows pc, including in IDLE and DONE.
  assign rom_addr  = pc_q;
  assign uop_data  = uop_data_q;
  assign uop_valid = uop_valid_q;
  assign indata    = indata_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Testbench for microcode_sequencer: table-driven runs, hand-written abort,
// simultaneous-handshake and reset sequences, then randomized runs. Each run
// is checked against the address range it should replay.
module tb_microcode_sequencer;

  logic       HCLK;
  logic       HRESETn;
  logic [7:0] s_addr;
  logic [7:0] e_addr;
  logic       ena;
  logic [7:0] rom_addr;
  logic [7:0] rom_rdata;
  logic [7:0] uop_data;
  logic       uop_valid;
  logic       uop_ready;
  logic [7:0] indata;
  logic       busy;
  logic       done;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] rom_mem [256];

  microcode_sequencer #(.AW(8), .DW(8)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .s_addr    (s_addr),
    .e_addr    (e_addr),
    .ena       (ena),
    .rom_addr  (rom_addr),
    .rom_rdata (rom_rdata),
    .uop_data  (uop_data),
    .uop_valid (uop_valid),
    .uop_ready (uop_ready),
    .indata    (indata),
    .busy      (busy),
    .done      (done)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Synchronous ROM: data for an address appears one cycle later.
  always @(posedge HCLK) rom_rdata <= rom_mem[rom_addr];

  typedef struct {
    logic [7:0] s;
    logic [7:0] e;
    int         pct;
    int         hold;
    int         exp_len;
    logic [7:0] exp_first;
    logic [7:0] exp_last;
  } run_vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic wait_valid(input string nm);
    int c;
    c = 0;
    while (!uop_valid && c < 20) begin
      step();
      c++;
    end
    check({nm, "_valid_seen"}, uop_valid, 1);
  endtask

  // One complete run from s to e. Expected data is ROM[(s+k) mod 256] for the k-th uop.
  task automatic do_run(input logic [7:0] s, input logic [7:0] e, input int pct, input int hold,
                        input string nm, output int n_out, output logic [7:0] first_out,
                        output logic [7:0] last_out);
    logic [7:0] diff;
    logic [7:0] a;
    logic [7:0] exp_d;
    int         len;
    int         k;
    int         cyc;
    int         vcnt;
    int         last_hs;
    int         budget;
    bit         finished;
    bit         hs;
    bit         chk_tp;

    diff      = e - s;
    len       = int'(diff) + 1;
    budget    = len * 60 + 20;
    chk_tp    = (pct >= 100) && (hold == 0);
    k         = 0;
    cyc       = 0;
    vcnt      = 0;
    last_hs   = -1;
    finished  = 0;
    first_out = 8'h00;
    last_out  = 8'h00;
    exp_d     = 8'h00;

    uop_ready = 1'b0;
    ena       = 1'b0;
    step();
    step();
    check({nm, "_idle_busy"}, busy, 0);
    check({nm, "_idle_done"}, done, 0);

    s_addr = s;
    e_addr = e;
    ena    = 1'b1;
    step();
    check({nm, "_start_busy"}, busy, 1);
    // The range was latched at start; these changes must have no effect.
    s_addr = 8'($urandom);
    e_addr = 8'($urandom);

    while (cyc < budget && !finished) begin
      if (done) begin
        finished = 1;
      end else begin
        a     = s + 8'(k);
        exp_d = rom_mem[a];
        check($sformatf("%s_rom_addr_k%0d", nm, k), rom_addr, a);
        check($sformatf("%s_busy_c%0d", nm, cyc), busy, 1);
        if (uop_valid) begin
          check($sformatf("%s_uop_k%0d", nm, k), uop_data, exp_d);
          if (chk_tp && k == 0 && vcnt == 0) check({nm, "_first_valid_cycle"}, cyc, 2);
          vcnt++;
        end
        uop_ready = (vcnt > hold) && ($urandom_range(99) < pct);
        hs = uop_valid && uop_ready;
        step();
        cyc++;
        if (hs) begin
          check($sformatf("%s_indata_k%0d", nm, k), indata, exp_d);
          if (chk_tp && last_hs >= 0) check($sformatf("%s_interval_k%0d", nm, k), cyc - last_hs, 3);
          if (k == 0) first_out = exp_d;
          last_out = exp_d;
          last_hs  = cyc;
          k++;
          vcnt = 0;
        end
      end
    end
    check({nm, "_finished_in_budget"}, finished, 1);
    uop_ready = 1'b0;
    n_out = k;
    check({nm, "_count"}, k, len);
    check({nm, "_final_indata"}, indata, last_out);
    check({nm, "_done_busy"}, busy, 0);
    check({nm, "_done_valid"}, uop_valid, 0);

    // Holding ena high keeps DONE; no second run starts.
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("%s_hold_done%0d", nm, i), done, 1);
      check($sformatf("%s_hold_busy%0d", nm, i), busy, 0);
    end
    ena = 1'b0;
    step();
    check({nm, "_release_done"}, done, 0);
  endtask

  run_vec_t vecs [6];

  initial begin
    int         n;
    logic [7:0] f;
    logic [7:0] l;
    logic [7:0] rs;
    logic [7:0] re;
    int         pct;
    int         hold;

    for (int i = 0; i < 256; i++) rom_mem[i] = 8'(i + 8'h10);

    // ROM[i] = i + 0x10 for the table-driven runs.
    vecs[0] = '{s: 8'h02, e: 8'h04, pct: 100, hold: 0, exp_len: 3,   exp_first: 8'h12, exp_last: 8'h14};
    vecs[1] = '{s: 8'hFE, e: 8'h01, pct: 100, hold: 0, exp_len: 4,   exp_first: 8'h0E, exp_last: 8'h11};
    vecs[2] = '{s: 8'h30, e: 8'h30, pct: 100, hold: 5, exp_len: 1,   exp_first: 8'h40, exp_last: 8'h40};
    vecs[3] = '{s: 8'hFF, e: 8'hFF, pct: 100, hold: 0, exp_len: 1,   exp_first: 8'h0F, exp_last: 8'h0F};
    vecs[4] = '{s: 8'h00, e: 8'hFF, pct: 100, hold: 0, exp_len: 256, exp_first: 8'h10, exp_last: 8'h0F};
    vecs[5] = '{s: 8'h80, e: 8'h85, pct: 40,  hold: 2, exp_len: 6,   exp_first: 8'h90, exp_last: 8'h95};

    HRESETn   = 1'b0;
    ena       = 1'b0;
    s_addr    = 8'h00;
    e_addr    = 8'h00;
    uop_ready = 1'b0;
    step();
    step();
    check("reset_rom_addr", rom_addr, 0);
    check("reset_uop_valid", uop_valid, 0);
    check("reset_uop_data", uop_data, 0);
    check("reset_indata", indata, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    HRESETn = 1'b1;
    step();

    for (int i = 0; i < 6; i++) begin
      do_run(vecs[i].s, vecs[i].e, vecs[i].pct, vecs[i].hold, $sformatf("vec%0d", i), n, f, l);
      check($sformatf("vec%0d_len", i), n, vecs[i].exp_len);
      check($sformatf("vec%0d_first", i), f, vecs[i].exp_first);
      check($sformatf("vec%0d_last", i), l, vecs[i].exp_last);
    end

    // Abort while the second uop is waiting for ready.
    ena = 1'b0;
    step();
    s_addr    = 8'h10;
    e_addr    = 8'h20;
    ena       = 1'b1;
    uop_ready = 1'b1;
    step();
    wait_valid("abort_u1");
    check("abort_u1_data", uop_data, 8'h20);
    step();
    uop_ready = 1'b0;
    check("abort_u1_indata", indata, 8'h20);
    wait_valid("abort_u2");
    check("abort_u2_data", uop_data, 8'h21);
    ena = 1'b0;
    step();
    check("abort_valid", uop_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_indata", indata, 8'h20);
    step();
    step();
    check("abort_stays_idle", busy, 0);

    // Ready and ena-low in the same cycle: the handshake completes, then IDLE.
    s_addr    = 8'h40;
    e_addr    = 8'h45;
    ena       = 1'b1;
    uop_ready = 1'b1;
    step();
    wait_valid("simul");
    ena = 1'b0;
    step();
    uop_ready = 1'b0;
    check("simul_indata", indata, 8'h50);
    check("simul_valid", uop_valid, 0);
    check("simul_busy", busy, 0);
    check("simul_done", done, 0);

    // Asynchronous reset in the middle of a run.
    step();
    s_addr    = 8'h50;
    e_addr    = 8'h60;
    ena       = 1'b1;
    uop_ready = 1'b1;
    for (int i = 0; i < 7; i++) step();
    check("prereset_indata", indata, 8'h61);
    #3;
    HRESETn = 1'b0;
    #1;
    check("async_rst_rom_addr", rom_addr, 0);
    check("async_rst_uop_valid", uop_valid, 0);
    check("async_rst_uop_data", uop_data, 0);
    check("async_rst_indata", indata, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_done", done, 0);
    @(posedge HCLK);
    #1;
    ena       = 1'b0;
    uop_ready = 1'b0;
    HRESETn   = 1'b1;
    step();
    do_run(8'h02, 8'h04, 100, 0, "post_reset", n, f, l);
    check("post_reset_last", l, 8'h14);

    // Randomized ROM contents and ranges.
    for (int i = 0; i < 256; i++) rom_mem[i] = 8'($urandom);
    for (int r = 0; r < 25; r++) begin
      rs = 8'($urandom);
      if ($urandom_range(4) == 0) re = 8'($urandom);
      else re = rs + 8'($urandom_range(30));
      if ($urandom_range(3) == 0) begin
        pct  = 100;
        hold = 0;
      end else begin
        pct  = 30 + int'($urandom_range(70));
        hold = int'($urandom_range(3));
      end
      do_run(rs, re, pct, hold, $sformatf("rnd%0d", r), n, f, l);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
